// File: rtl/l1_mem_arbiter_pkg.sv
// Shared types and constants for the L1 I/D memory-port arbiter.
package l1_mem_arbiter_pkg;

    localparam int unsigned LINE_BITS = 128;

    // Requester IDs; also used as bit indices into per-port vectors.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_e;

    // Memory transactions are always whole lines.
    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & ~32'h0000_000F;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: rr breaks ties, otherwise the lone requester wins.
module rr_pick2
    import l1_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    output logic       grant_valid,
    output logic       grant_id
);

    // Combinational pick.
    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_I;
        if (req == 2'b11) begin
            grant_id = rr;
        end else if (req[PORT_D]) begin
            grant_id = PORT_D;
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one line-wide req/ack memory port between the I- and D-side L1 caches.
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_ren,
    input  logic                 i_wen,
    input  logic [31:0]          i_addr,
    input  logic [LINE_BITS-1:0] i_in,
    output logic [LINE_BITS-1:0] i_out,
    output logic                 i_busy,
    input  logic                 d_ren,
    input  logic                 d_wen,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_in,
    output logic [LINE_BITS-1:0] d_out,
    output logic                 d_busy,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 mem_err
);

    arb_state_e           state_q, state_d;
    logic                 rr_q, rr_d;
    logic [1:0]           cool_q, cool_d;
    logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
    logic                 gnt_q, gnt_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] i_out_q, i_out_d;
    logic [LINE_BITS-1:0] d_out_q, d_out_d;
    logic [1:0]           busy_q, busy_d;
    logic                 err_q, err_d;

    logic [1:0]           eligible;
    logic                 pick_valid;
    logic                 pick_id;

    // A port just served sits out one IDLE cycle so its stale request is not re-granted.
    assign eligible = {d_ren | d_wen, i_ren | i_wen} & ~cool_q;

    rr_pick2 u_pick (
        .req         (eligible),
        .rr          (rr_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Next-state, latches, timeout and response logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cool_d  = cool_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        i_out_d = i_out_q;
        d_out_d = d_out_q;
        busy_d  = 2'b11;
        err_d   = err_q;

        unique case (state_q)
            ARB_IDLE: begin
                cool_d = 2'b00;
                if (pick_valid) begin
                    gnt_d = pick_id;
                    if (pick_id == PORT_D) begin
                        we_d    = d_wen;
                        addr_d  = line_addr(d_addr);
                        wdata_d = d_wen ? d_in : '0;
                    end else begin
                        we_d    = i_wen;
                        addr_d  = line_addr(i_addr);
                        wdata_d = i_wen ? i_in : '0;
                    end
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack || (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1))) begin
                    req_d          = 1'b0;
                    state_d        = ARB_DONE;
                    busy_d[gnt_q]  = 1'b0;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end
                    if (!we_q) begin
                        if (gnt_q == PORT_D) begin
                            d_out_d = mem_ack ? mem_rdata : '0;
                        end else begin
                            i_out_d = mem_ack ? mem_rdata : '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            ARB_DONE: begin
                rr_d          = ~gnt_q;
                cool_d[gnt_q] = 1'b1;
                state_d       = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            rr_q    <= PORT_I;
            cool_q  <= 2'b00;
            cnt_q   <= '0;
            gnt_q   <= PORT_I;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_out_q <= '0;
            d_out_q <= '0;
            busy_q  <= 2'b11;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cool_q  <= cool_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            i_out_q <= i_out_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_out     = i_out_q;
    assign d_out     = d_out_q;
    assign i_busy    = busy_q[PORT_I];
    assign d_busy    = busy_q[PORT_D];
    assign mem_err   = err_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: expected memory requests and cache responses
// are queued with the stimulus; negedge monitors pop and compare.
module tb_l1_mem_arbiter;

    localparam int unsigned TO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_ren, i_wen, d_ren, d_wen;
    logic [31:0]  i_addr, d_addr, mem_addr;
    logic [127:0] i_in, d_in, i_out, d_out, mem_wdata, mem_rdata;
    logic         i_busy, d_busy, mem_req, mem_we, mem_ack, mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_ren     (i_ren),
        .i_wen     (i_wen),
        .i_addr    (i_addr),
        .i_in      (i_in),
        .i_out     (i_out),
        .i_busy    (i_busy),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_busy    (d_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err)
    );

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic         port;
        logic [127:0] out;
        logic         err;
    } rsp_exp_t;

    mem_exp_t     mem_q[$];
    rsp_exp_t     rsp_q[$];
    logic [127:0] model_out[2];
    logic         model_err;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] addr_line(input logic [31:0] a);
        return {4{(a & ~32'hF) ^ 32'h5A5A_0000}};
    endfunction

    // Memory responder.
    int           ack_delay = 2;
    int           req_cycles = 0;
    bit           late_ack = 1'b0;
    bit           rdata_use_addr = 1'b0;
    logic [127:0] rdata_fixed = '0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (late_ack) begin
                mem_ack  = 1'b1;
                late_ack = 1'b0;
            end else if (mem_req === 1'b1) begin
                req_cycles++;
                if (ack_delay >= 0 && req_cycles == ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_use_addr ? addr_line(mem_addr) : rdata_fixed;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // Memory-side monitor: one check set per new request.
    logic req_seen = 1'b0;
    always @(negedge clk) begin
        mem_exp_t m;
        if (mem_req === 1'b1 && !req_seen) begin
            if (mem_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_req: got addr %h, required no request", mem_addr);
            end else begin
                m = mem_q.pop_front();
                chk("mem_we", 128'(mem_we), 128'(m.we));
                chk("mem_addr", 128'(mem_addr), 128'(m.addr));
                chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
        req_seen <= (mem_req === 1'b1);
    end

    // Cache-side monitor: one check set per busy-low cycle.
    always @(negedge clk) begin
        rsp_exp_t r;
        logic     p;
        if (i_busy === 1'b0 || d_busy === 1'b0) begin
            p = (d_busy === 1'b0);
            if (i_busy === 1'b0 && d_busy === 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_busy_low: got i_busy=0 d_busy=0, required one high");
            end
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_busy_low: got port %0d, required no response", p);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_port", 128'(p), 128'(r.port));
                chk("rsp_out", p ? d_out : i_out, r.out);
                chk("rsp_err", 128'(mem_err), 128'(r.err));
            end
        end
    end

    task automatic push_op(input logic port, input logic we, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [127:0] rdata,
                           input logic tmo);
        mem_exp_t m;
        rsp_exp_t r;
        m.we    = we;
        m.addr  = addr & ~32'hF;
        m.wdata = we ? wdata : '0;
        mem_q.push_back(m);
        if (!we) model_out[port] = tmo ? 128'd0 : rdata;
        if (tmo) model_err = 1'b1;
        r.port = port;
        r.out  = model_out[port];
        r.err  = model_err;
        rsp_q.push_back(r);
    endtask

    // Cache-side driver: request, wait for busy-low, hold `hold` more edges, release.
    task automatic cache_op(input logic port, input logic we, input logic [31:0] addr,
                            input logic [127:0] data, input int hold, input int exp_lat);
        int t = 0;
        @(posedge clk);
        #1;
        if (port) begin
            d_ren = !we; d_wen = we; d_addr = addr; d_in = data;
        end else begin
            i_ren = !we; i_wen = we; i_addr = addr; i_in = data;
        end
        while (((port ? d_busy : i_busy) !== 1'b0) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_wait: got no busy-low in 60 cycles on port %0d, required one", port);
        end else if (exp_lat >= 0) begin
            chk("latency", 128'(t), 128'(exp_lat));
        end
        repeat (hold) @(posedge clk);
        #1;
        if (port) begin
            d_ren = 1'b0; d_wen = 1'b0;
        end else begin
            i_ren = 1'b0; i_wen = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_exp_t m;
        reset = 1'b0;
        i_ren = 1'b0; i_wen = 1'b0; i_addr = '0; i_in = '0;
        d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_in = '0;
        model_out[0] = '0;
        model_out[1] = '0;
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_i_out", i_out, 128'(0));
        chk("rst_d_out", d_out, 128'(0));
        chk("rst_busy", 128'({i_busy, d_busy}), 128'(2'b11));
        chk("rst_mem_err", 128'(mem_err), 128'(0));
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Single D read, ack two cycles after mem_req.
        rdata_fixed = {16{8'hA5}};
        ack_delay   = 2;
        push_op(1'b1, 1'b0, 32'h0000_1234, '0, {16{8'hA5}}, 1'b0);
        cache_op(1'b1, 1'b0, 32'h0000_1234, '0, 0, 4);
        repeat (3) @(posedge clk);

        // Sustained contention: I, D, I, D.
        rdata_use_addr = 1'b1;
        push_op(1'b0, 1'b0, 32'h0000_0100, '0, addr_line(32'h0000_0100), 1'b0);
        push_op(1'b1, 1'b0, 32'h0000_0200, '0, addr_line(32'h0000_0200), 1'b0);
        push_op(1'b0, 1'b0, 32'h0000_0300, '0, addr_line(32'h0000_0300), 1'b0);
        push_op(1'b1, 1'b0, 32'h0000_0400, '0, addr_line(32'h0000_0400), 1'b0);
        fork
            begin
                cache_op(1'b0, 1'b0, 32'h0000_0100, '0, 0, -1);
                cache_op(1'b0, 1'b0, 32'h0000_0300, '0, 0, -1);
            end
            begin
                cache_op(1'b1, 1'b0, 32'h0000_0200, '0, 0, -1);
                cache_op(1'b1, 1'b0, 32'h0000_0400, '0, 0, -1);
            end
        join
        repeat (3) @(posedge clk);

        // Lone I read leaves rr on D; a later simultaneous pair must serve D first.
        push_op(1'b0, 1'b0, 32'h0000_0500, '0, addr_line(32'h0000_0500), 1'b0);
        cache_op(1'b0, 1'b0, 32'h0000_0500, '0, 0, 4);
        repeat (3) @(posedge clk);
        push_op(1'b1, 1'b0, 32'h0000_0610, '0, addr_line(32'h0000_0610), 1'b0);
        push_op(1'b0, 1'b0, 32'h0000_0620, '0, addr_line(32'h0000_0620), 1'b0);
        fork
            cache_op(1'b0, 1'b0, 32'h0000_0620, '0, 0, -1);
            cache_op(1'b1, 1'b0, 32'h0000_0610, '0, 0, -1);
        join
        repeat (3) @(posedge clk);

        // D write-back leaves d_out unchanged.
        push_op(1'b1, 1'b1, 32'h0000_2040, 128'h0123456789ABCDEF0123456789ABCDEF, '0, 1'b0);
        cache_op(1'b1, 1'b1, 32'h0000_2040, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 4);
        repeat (3) @(posedge clk);

        // Cooldown: D holds d_ren through the IDLE cycle after its busy-low.
        push_op(1'b1, 1'b0, 32'h0000_3000, '0, addr_line(32'h0000_3000), 1'b0);
        cache_op(1'b1, 1'b0, 32'h0000_3000, '0, 2, 4);
        repeat (6) @(posedge clk);

        // Ack in the last allowed cycle is a success.
        ack_delay = TO - 1;
        push_op(1'b0, 1'b0, 32'h0000_5008, '0, addr_line(32'h0000_5008), 1'b0);
        cache_op(1'b0, 1'b0, 32'h0000_5008, '0, 0, TO + 1);
        repeat (3) @(posedge clk);

        // Timeout on an I read, then a normal D read.
        ack_delay = -1;
        push_op(1'b0, 1'b0, 32'h0000_6000, '0, '0, 1'b1);
        cache_op(1'b0, 1'b0, 32'h0000_6000, '0, 0, TO + 1);
        #1;
        chk("err_sticky", 128'(mem_err), 128'(1));
        ack_delay = 2;
        repeat (3) @(posedge clk);
        push_op(1'b1, 1'b0, 32'h0000_7000, '0, addr_line(32'h0000_7000), 1'b0);
        cache_op(1'b1, 1'b0, 32'h0000_7000, '0, 0, 4);
        repeat (3) @(posedge clk);

        // Reset during ISSUE; a late ack must not produce a busy-low pulse.
        ack_delay = -1;
        m.we = 1'b0; m.addr = 32'h0000_8000; m.wdata = '0;
        mem_q.push_back(m);
        @(posedge clk);
        #1;
        i_ren = 1'b1; i_addr = 32'h0000_8000;
        for (int i = 0; i < 10 && mem_req !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_issue_req_up", 128'(mem_req), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_ren = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_mem_req", 128'(mem_req), 128'(0));
        chk("midrst_busy", 128'({i_busy, d_busy}), 128'(2'b11));
        chk("midrst_mem_err", 128'(mem_err), 128'(0));
        chk("midrst_d_out", d_out, 128'(0));
        reset = 1'b1;
        late_ack = 1'b1;
        model_out[0] = '0;
        model_out[1] = '0;
        model_err = 1'b0;
        repeat (6) @(posedge clk);

        // Recovery after reset.
        ack_delay = 0;
        push_op(1'b0, 1'b0, 32'h0000_9000, '0, addr_line(32'h0000_9000), 1'b0);
        cache_op(1'b0, 1'b0, 32'h0000_9000, '0, 0, 2);
        repeat (4) @(posedge clk);

        chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
        chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
